// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: each accepted 64-bit-bus transfer becomes one or two 32-bit APB beats.
// Optional APB4 write strobes (PSTRB) when AHB_APB_PSTRB_EN is defined.
module ahb_apb_bridge #(
  parameter int unsigned PADDR_WIDTH    = 16,
  parameter int unsigned PREADY_TIMEOUT = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSELS,
  input  logic [1:0]             HTRANSS,
  input  logic                   HWRITES,
  input  logic [2:0]             HSIZES,
  input  logic [31:0]            HADDRS,
  input  logic [63:0]            HWDATA,
  input  logic                   HREADYMUXS,
  output logic [63:0]            HRDATAS,
  output logic                   HRESPS,
  output logic                   HREADYoutS,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [PADDR_WIDTH-1:0] PADDR,
  output logic [31:0]            PWDATA,
`ifdef AHB_APB_PSTRB_EN
  output logic [3:0]             PSTRB,
`endif
  input  logic [31:0]            PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int unsigned CW = (PREADY_TIMEOUT > 1) ? $clog2(PREADY_TIMEOUT) : 1;
  localparam bit          TIMEOUT_EN = (PREADY_TIMEOUT != 0);
  localparam logic [CW-1:0] TCNT_LAST = CW'(PREADY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP1, ACCESS1, SETUP2, ACCESS2, DONE, ERR1, ERR2
  } state_t;

  state_t         state_q, state_d;
  logic           is64_q;
  logic           lane_hi_q;
  logic [31:0]    addr_q;
  logic [CW-1:0]  tcnt_q;

  logic           accept, idle_like, start, size64, bad_size, in_access, timeout;
  logic [31:0]    base;
  logic           psel_d, penable_d, hready_d, hresp_d;
  logic           unused_bits;

  // HTRANSS[0] (NONSEQ vs SEQ) is irrelevant here; HADDRS[1:0] only feeds strobes
  assign unused_bits = ^{HTRANSS[0], HADDRS[1:0]};

  assign accept    = HSELS & HTRANSS[1] & HREADYMUXS;
  assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR2);
  assign start     = idle_like & accept;
  assign size64    = (HSIZES == 3'd3);
  assign bad_size  = (HSIZES > 3'd3) || (size64 && (HADDRS[2:0] != 3'b000));
  assign in_access = (state_q == ACCESS1) || (state_q == ACCESS2);
  assign timeout   = TIMEOUT_EN && !PREADY && (tcnt_q == TCNT_LAST);
  assign base      = {HADDRS[31:3], HADDRS[2] & ~size64, 2'b00};

  // Data-phase write lane straight from HWDATA; the master holds it through wait states
  assign PWDATA = lane_hi_q ? HWDATA[63:32] : HWDATA[31:0];

  always_comb begin
    state_d   = state_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    hready_d  = 1'b1;
    hresp_d   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR2: begin
        if (accept) state_d = bad_size ? ERR1 : SETUP1;
        else        state_d = IDLE;
      end
      SETUP1:  state_d = ACCESS1;
      ACCESS1: begin
        if (PREADY)       state_d = PSLVERR ? ERR1 : (is64_q ? SETUP2 : DONE);
        else if (timeout) state_d = ERR1;
      end
      SETUP2:  state_d = ACCESS2;
      ACCESS2: begin
        if (PREADY)       state_d = PSLVERR ? ERR1 : DONE;
        else if (timeout) state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
    case (state_d)
      SETUP1, SETUP2: begin
        psel_d   = 1'b1;
        hready_d = 1'b0;
      end
      ACCESS1, ACCESS2: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        hready_d  = 1'b0;
      end
      ERR1: begin
        hready_d = 1'b0;
        hresp_d  = 1'b1;
      end
      ERR2:    hresp_d = 1'b1;
      default: ;
    endcase
  end

`ifdef AHB_APB_PSTRB_EN
  logic [3:0] strb_d;

  // Sub-word strobes from size and byte offset; reads carry no strobes
  always_comb begin
    strb_d = 4'h0;
    if (HWRITES) begin
      case (HSIZES)
        3'd0:    strb_d = 4'b0001 << HADDRS[1:0];
        3'd1:    strb_d = HADDRS[1] ? 4'b1100 : 4'b0011;
        default: strb_d = 4'hF;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)     PSTRB <= 4'h0;
    else if (start) PSTRB <= strb_d;
  end
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      HREADYoutS <= 1'b1;
      HRESPS     <= 1'b0;
    end else begin
      state_q    <= state_d;
      PSEL       <= psel_d;
      PENABLE    <= penable_d;
      HREADYoutS <= hready_d;
      HRESPS     <= hresp_d;
    end
  end

  // Address-phase capture, beat-2 address step, timeout counter and read capture
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      HRDATAS   <= '0;
      is64_q    <= 1'b0;
      lane_hi_q <= 1'b0;
      addr_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      if (start) begin
        PWRITE    <= HWRITES;
        PADDR     <= PADDR_WIDTH'(base);
        addr_q    <= base;
        is64_q    <= size64;
        lane_hi_q <= base[2];
      end else if ((state_q == ACCESS1) && (state_d == SETUP2)) begin
        PADDR     <= PADDR_WIDTH'(addr_q + 32'd4);
        lane_hi_q <= 1'b1;
      end

      if ((state_q == SETUP1) || (state_q == SETUP2)) tcnt_q <= '0;
      else if (in_access && !PREADY)                   tcnt_q <= tcnt_q + CW'(1);

      if (in_access && PREADY && !PWRITE) begin
        if (!is64_q)                HRDATAS         <= {PRDATA, PRDATA};
        else if (state_q == ACCESS1) HRDATAS[31:0]  <= PRDATA;
        else                         HRDATAS[63:32] <= PRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Randomized bench for ahb_apb_bridge: a transfer-level model sets per-cycle expectations, a negedge process compares.
module tb_ahb_apb_bridge;

  localparam int TO = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [31:0] HADDRS;
  logic [63:0] HWDATA;
  logic        HREADYMUXS;
  logic [63:0] HRDATAS;
  logic        HRESPS;
  logic        HREADYoutS;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
`ifdef AHB_APB_PSTRB_EN
  logic [3:0]  PSTRB;
`endif

  ahb_apb_bridge #(.PADDR_WIDTH(16), .PREADY_TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HADDRS(HADDRS), .HWDATA(HWDATA), .HREADYMUXS(HREADYMUXS),
    .HRDATAS(HRDATAS), .HRESPS(HRESPS), .HREADYoutS(HREADYoutS),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef AHB_APB_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Single slave on the bus: bus-wide HREADY follows this slave
  assign HREADYMUXS = HREADYoutS;

  always #5 HCLK = ~HCLK;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  logic        e_rdy, e_resp, e_psel, e_pen, e_pwrite;
  logic [15:0] e_paddr;
  logic [31:0] e_pwdata;
  logic [3:0]  e_pstrb;
  logic [63:0] e_rdata;
  int n_setup, n_access, n_wait, n_err;
  logic [15:0] log_paddr[$];
  logic [31:0] log_pwdata[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("hready", 64'(HREADYoutS), 64'(e_rdy));
      chk("hresp", 64'(HRESPS), 64'(e_resp));
      chk("hrdata", HRDATAS, e_rdata);
      chk("psel", 64'(PSEL), 64'(e_psel));
      chk("penable", 64'(PENABLE), 64'(e_pen));
      if (e_psel) begin
        chk("paddr", 64'(PADDR), 64'(e_paddr));
        chk("pwrite", 64'(PWRITE), 64'(e_pwrite));
        if (e_pwrite) chk("pwdata", 64'(PWDATA), 64'(e_pwdata));
`ifdef AHB_APB_PSTRB_EN
        chk("pstrb", 64'(PSTRB), 64'(e_pstrb));
`endif
      end
      if (PSEL && !PENABLE) begin
        n_setup++;
        log_paddr.push_back(PADDR);
        log_pwdata.push_back(PWDATA);
      end
      if (PENABLE) n_access++;
      if (!HREADYoutS) n_wait++;
      if (HRESPS) n_err++;
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic resp, input logic psel, input logic pen);
    e_rdy = rdy; e_resp = resp; e_psel = psel; e_pen = pen;
  endtask

  // Address inputs that never form an accept, plus idle APB inputs
  task automatic idle_inputs();
    HSELS   = 1'($urandom);
    HTRANSS = HSELS ? 2'($urandom_range(0, 1)) : 2'($urandom);
    HWRITES = 1'($urandom);
    HSIZES  = 3'($urandom);
    HADDRS  = $urandom;
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
  endtask

  // Anything goes while the slave stalls the bus
  task automatic busy_inputs();
    HSELS   = 1'($urandom);
    HTRANSS = 2'($urandom);
    HWRITES = 1'($urandom);
    HSIZES  = 3'($urandom);
    HADDRS  = $urandom;
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
  endtask

  task automatic idle_cyc();
    step();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic clr();
    n_setup = 0; n_access = 0; n_wait = 0; n_err = 0;
    log_paddr.delete();
    log_pwdata.delete();
  endtask

  // One AHB transfer, from its address phase (current cycle) to its HREADY=1 completion cycle
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] addr, input logic [63:0] wd,
                      input int w1, input int w2, input logic er1, input logic er2,
                      input logic [31:0] rd1, input logic [31:0] rd2);
    logic bad, is64, fail, rdy_now, er;
    logic [31:0] base, pa, rv;
    int nb, w;
    HSELS = 1'b1; HTRANSS = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    HWRITES = wr; HSIZES = sz; HADDRS = addr;
    step();
    busy_inputs();
    HWDATA = wd;
    bad  = (sz > 3'd3) || ((sz == 3'd3) && (addr[2:0] != 3'b000));
    is64 = (sz == 3'd3);
    fail = 1'b0;
    if (!bad) begin
      base = {addr[31:2], 2'b00};
      if (is64) base[2] = 1'b0;
      nb = is64 ? 2 : 1;
      for (int b = 0; b < nb && !fail; b++) begin
        pa       = base + 32'(4 * b);
        e_paddr  = pa[15:0];
        e_pwrite = wr;
        e_pwdata = ((b == 1) || (!is64 && base[2])) ? wd[63:32] : wd[31:0];
        if (!wr)           e_pstrb = 4'h0;
        else if (sz == 3'd0) e_pstrb = 4'b0001 << addr[1:0];
        else if (sz == 3'd1) e_pstrb = addr[1] ? 4'b1100 : 4'b0011;
        else               e_pstrb = 4'hF;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        busy_inputs();
        w  = (b == 1) ? w2 : w1;
        er = (b == 1) ? er2 : er1;
        rv = (b == 1) ? rd2 : rd1;
        for (int k = 0; k < 100; k++) begin
          set_exp(1'b0, 1'b0, 1'b1, 1'b1);
          rdy_now = (k >= w);
          PREADY  = rdy_now;
          PSLVERR = rdy_now & er;
          PRDATA  = rdy_now ? rv : $urandom;
          step();
          busy_inputs();
          if (rdy_now) begin
            if (!wr) begin
              if (!is64)       e_rdata = {rv, rv};
              else if (b == 0) e_rdata[31:0] = rv;
              else             e_rdata[63:32] = rv;
            end
            if (er) fail = 1'b1;
            break;
          end
          if (k + 1 == TO) begin
            fail = 1'b1;
            break;
          end
        end
      end
    end
    if (bad || fail) begin
      set_exp(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      busy_inputs();
      set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    end else begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle_inputs();
  endtask

  task automatic settle();
    @(negedge HCLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    int w1, w2;
    e_rdata = '0; e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0; e_pstrb = '0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    HRESET = 1'b1;
    HWDATA = '0;
    idle_inputs();
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    chk_en = 1'b1;
    settle();
    chk("rst_hready", 64'(HREADYoutS), 64'd1);
    chk("rst_hresp", 64'(HRESPS), 64'd0);
    chk("rst_hrdata", HRDATAS, 64'd0);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);

    // 32-bit read, zero APB wait
    idle_cyc(); clr();
    xfer(1'b0, 3'd2, 32'h0000_0104, 64'd0, 0, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'd0);
    settle();
    chk("rd32_hrdata", HRDATAS, 64'hCAFEF00D_CAFEF00D);
    chk("rd32_hready", 64'(HREADYoutS), 64'd1);
    chk("rd32_waits", 64'(n_wait), 64'd2);
    chk("rd32_paddr", 64'(log_paddr[0]), 64'h0104);

    // 64-bit write, two beats
    idle_cyc(); clr();
    xfer(1'b1, 3'd3, 32'h0000_0010, 64'h11112222_33334444, 0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    chk("wr64_setups", 64'(n_setup), 64'd2);
    chk("wr64_paddr1", 64'(log_paddr[0]), 64'h0010);
    chk("wr64_pwdata1", 64'(log_pwdata[0]), 64'h33334444);
    chk("wr64_paddr2", 64'(log_paddr[1]), 64'h0014);
    chk("wr64_pwdata2", 64'(log_pwdata[1]), 64'h11112222);
    chk("wr64_waits", 64'(n_wait), 64'd4);
    chk("wr64_hresp", 64'(HRESPS), 64'd0);

    // 64-bit read with slave error on beat 1
    idle_cyc(); clr();
    xfer(1'b0, 3'd3, 32'h0000_0020, 64'd0, 0, 0, 1'b1, 1'b0, 32'h1234_5678, 32'd0);
    settle();
    chk("err64_setups", 64'(n_setup), 64'd1);
    chk("err64_errcycles", 64'(n_err), 64'd2);

    // Misaligned doubleword: no APB access
    idle_cyc(); clr();
    xfer(1'b1, 3'd3, 32'h0000_0004, 64'd0, 0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    chk("mis_setups", 64'(n_setup), 64'd0);
    chk("mis_errcycles", 64'(n_err), 64'd2);

    // PREADY stuck low
    idle_cyc(); clr();
    xfer(1'b1, 3'd2, 32'h0000_0040, 64'hAAAA_BBBB_CCCC_DDDD, 50, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    chk("to_access", 64'(n_access), 64'(TO));
    chk("to_errcycles", 64'(n_err), 64'd2);

    // Back-to-back from DONE
    idle_cyc(); clr();
    xfer(1'b0, 3'd2, 32'h0000_0108, 64'd0, 0, 0, 1'b0, 1'b0, 32'h0BAD_BEEF, 32'd0);
    xfer(1'b1, 3'd0, 32'h0000_010D, 64'h5555_6666_7777_8888, 1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    settle();
    chk("b2b_setups", 64'(n_setup), 64'd2);
    chk("b2b_waits", 64'(n_wait), 64'd5);

    // Reset in the middle of ACCESS1
    idle_cyc();
    HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = 1'b0; HSIZES = 3'd2; HADDRS = 32'h0000_0200;
    step(); busy_inputs();
    e_paddr = 16'h0200; e_pwrite = 1'b0; e_pstrb = 4'h0;
    set_exp(1'b0, 1'b0, 1'b1, 1'b0);
    step(); busy_inputs(); PREADY = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    HRESET = 1'b1;
    e_rdata = '0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mrst_psel", 64'(PSEL), 64'd0);
    chk("mrst_penable", 64'(PENABLE), 64'd0);
    chk("mrst_hready", 64'(HREADYoutS), 64'd1);
    chk("mrst_hresp", 64'(HRESPS), 64'd0);
    chk("mrst_hrdata", HRDATAS, 64'd0);
    step();
    HRESET = 1'b0;
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j < $urandom_range(1, 3); j++) idle_cyc();
      end
      sz = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) sz = 3'($urandom_range(4, 7));
      ad = $urandom;
      if (sz == 3'd3 && $urandom_range(0, 2) != 0) ad[2:0] = 3'b000;
      w1 = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      w2 = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      xfer(1'($urandom), sz, ad, {$urandom, $urandom}, w1, w2,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom, $urandom);
    end
    idle_cyc();
    idle_cyc();
    settle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
